// File: rtl/uart_cmd_parser_pkg.sv
// Shared ASCII constants, FSM encodings and hex decode for the UART command parser.
// Pure declarations: no logic, no latency.
package uart_cmd_pkg;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_C    = 8'h43;
  localparam logic [7:0] ASCII_C_LC = 8'h63;
  localparam logic [7:0] ASCII_T    = 8'h54;
  localparam logic [7:0] ASCII_T_LC = 8'h74;
  localparam logic [7:0] ASCII_K    = 8'h4B;
  localparam logic [7:0] ASCII_NAK  = 8'h3F;

  typedef enum logic [1:0] {
    P_IDLE   = 2'd0,
    P_HEX_HI = 2'd1,
    P_HEX_LO = 2'd2,
    P_CR     = 2'd3
  } parse_state_t;

  typedef enum logic [1:0] {
    T_IDLE      = 2'd0,
    T_WAIT_BUSY = 2'd1,
    T_WAIT_DONE = 2'd2
  } tx_state_t;

  typedef struct packed {
    logic       vld;
    logic [3:0] nib;
  } hex_t;

  function automatic hex_t hex_decode(input logic [7:0] c);
    hex_t r;
    r.vld = 1'b1;
    r.nib = 4'h0;
    if (c >= 8'h30 && c <= 8'h39)
      r.nib = c[3:0];
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      r.nib = c[3:0] + 4'd9;  // 'A'/'a' low nibble is 1
    else
      r.vld = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// UART-side signal bundle: receive strobe/byte in, transmit start/byte out, busy back.
// master = UART core side, slave = command parser side.
interface uart_cmd_parser_if;
  logic       i_Received;
  logic [7:0] i_Data;
  logic       i_TxBusy;
  logic       o_TxStart;
  logic [7:0] o_TxData;

  modport master (output i_Received, output i_Data, output i_TxBusy,
                  input  o_TxStart,  input  o_TxData);
  modport slave  (input  i_Received, input  i_Data, input  i_TxBusy,
                  output o_TxStart,  output o_TxData);
endinterface

// File: rtl/uart_cmd_parser_tx_byte_fifo.sv
// First-word-fall-through byte queue; head visible combinationally, push/pop in one cycle.
// A push while full is refused unless a pop frees the slot in the same cycle.
module tx_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge Clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign pop_dat = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/uart_cmd_parser.sv
// ASCII command parser: echoes every byte, answers K/?, drives override or timer colour.
// Echo launches next cycle when idle; responses queue one cycle later; a full queue drops with o_Error.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int TX_FIFO_DEPTH = 4,
  parameter int CMD_TIMEOUT   = 13300000
) (
  input  logic                Clock,
  input  logic                Reset,
  uart_cmd_parser_if.slave    uart,
  input  logic [7:0]          i_TimerColour,
  output logic [7:0]          o_Colour,
  output logic                o_Override,
  output logic                o_Error
);

  localparam int TO_W = (CMD_TIMEOUT > 1) ? $clog2(CMD_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(CMD_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  parse_state_t    p_state;
  parse_state_t    p_next;
  hex_t            hex;
  logic [3:0]      nib_hi;
  logic [3:0]      nib_lo;
  logic            pend_timer;
  logic [7:0]      colour_reg;
  logic            resp_vld;
  logic [7:0]      resp_dat;
  logic [TO_W-1:0] to_cnt;

  logic            ld_hi;
  logic            ld_lo;
  logic            set_pend;
  logic            clr_pend;
  logic            commit;
  logic            resp_set;
  logic [7:0]      resp_code;
  logic            parse_err;
  logic            timeout_hit;
  logic            is_c;
  logic            is_t;

  tx_state_t       t_state;
  tx_state_t       t_next;
  logic [1:0]      wb_cnt;
  logic            push_vld;
  logic [7:0]      push_dat;
  logic            launch;
  logic [7:0]      launch_dat;
  logic            fifo_push;
  logic            fifo_pop;
  logic [7:0]      fifo_head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            drop;

  assign hex  = hex_decode(uart.i_Data);
  assign is_c = (uart.i_Data == ASCII_C) || (uart.i_Data == ASCII_C_LC);
  assign is_t = (uart.i_Data == ASCII_T) || (uart.i_Data == ASCII_T_LC);

  always_comb begin
    p_next      = p_state;
    ld_hi       = 1'b0;
    ld_lo       = 1'b0;
    set_pend    = 1'b0;
    clr_pend    = 1'b0;
    commit      = 1'b0;
    resp_set    = 1'b0;
    resp_code   = ASCII_NAK;
    parse_err   = 1'b0;
    timeout_hit = 1'b0;
    if (uart.i_Received) begin
      if (uart.i_Data != ASCII_LF) begin
        case (p_state)
          P_IDLE: begin
            if (is_c) begin
              p_next = P_HEX_HI;
            end else if (is_t) begin
              set_pend = 1'b1;
              p_next   = P_CR;
            end else if (uart.i_Data != ASCII_CR) begin
              parse_err = 1'b1;
            end
          end
          P_HEX_HI: begin
            if (hex.vld) begin
              ld_hi  = 1'b1;
              p_next = P_HEX_LO;
            end else begin
              parse_err = 1'b1;
            end
          end
          P_HEX_LO: begin
            if (hex.vld) begin
              ld_lo    = 1'b1;
              clr_pend = 1'b1;
              p_next   = P_CR;
            end else begin
              parse_err = 1'b1;
            end
          end
          P_CR: begin
            if (uart.i_Data == ASCII_CR) begin
              commit    = 1'b1;
              resp_set  = 1'b1;
              resp_code = ASCII_K;
              p_next    = P_IDLE;
            end else begin
              parse_err = 1'b1;
            end
          end
          default: p_next = P_IDLE;
        endcase
        if (parse_err) begin
          resp_set  = 1'b1;
          resp_code = ASCII_NAK;
          p_next    = P_IDLE;
        end
      end
    end else if (p_state != P_IDLE && to_cnt == TO_LAST) begin
      p_next      = P_IDLE;
      timeout_hit = 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      p_state    <= P_IDLE;
      nib_hi     <= 4'h0;
      nib_lo     <= 4'h0;
      pend_timer <= 1'b0;
      colour_reg <= 8'h00;
      o_Override <= 1'b0;
      resp_vld   <= 1'b0;
      resp_dat   <= 8'h00;
      to_cnt     <= '0;
      o_Error    <= 1'b0;
      o_Colour   <= 8'h00;
    end else begin
      p_state <= p_next;
      if (ld_hi) nib_hi <= hex.nib;
      if (ld_lo) nib_lo <= hex.nib;
      if (set_pend)      pend_timer <= 1'b1;
      else if (clr_pend) pend_timer <= 1'b0;
      if (commit) begin
        if (pend_timer) begin
          o_Override <= 1'b0;
        end else begin
          colour_reg <= {nib_hi, nib_lo};
          o_Override <= 1'b1;
        end
      end
      resp_vld <= resp_set;
      resp_dat <= resp_code;
      if (uart.i_Received)      to_cnt <= '0;
      else if (to_cnt != TO_LAST) to_cnt <= to_cnt + TO_ONE;
      o_Error  <= parse_err | timeout_hit | drop;
      o_Colour <= o_Override ? colour_reg : i_TimerColour;
    end
  end

  // Echo and response never coincide: bytes arrive at most once per UART frame.
  assign push_vld   = uart.i_Received | resp_vld;
  assign push_dat   = uart.i_Received ? uart.i_Data : resp_dat;

  // An empty queue is bypassed so an echo can start the very next cycle.
  assign launch     = (t_state == T_IDLE) && !uart.i_TxBusy && (!fifo_empty || push_vld);
  assign launch_dat = fifo_empty ? push_dat : fifo_head;
  assign fifo_pop   = launch && !fifo_empty;
  assign fifo_push  = push_vld && !(launch && fifo_empty);
  assign drop       = fifo_push && fifo_full && !fifo_pop;

  tx_byte_fifo #(
    .DEPTH (TX_FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .Clock    (Clock),
    .Reset    (Reset),
    .push     (fifo_push),
    .push_dat (push_dat),
    .pop      (fifo_pop),
    .pop_dat  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    t_next = t_state;
    case (t_state)
      T_IDLE:      if (launch) t_next = T_WAIT_BUSY;
      T_WAIT_BUSY: begin
        if (uart.i_TxBusy)        t_next = T_WAIT_DONE;
        else if (wb_cnt == 2'd3)  t_next = T_IDLE;
      end
      T_WAIT_DONE: if (!uart.i_TxBusy) t_next = T_IDLE;
      default:     t_next = T_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      t_state        <= T_IDLE;
      wb_cnt         <= 2'd0;
      uart.o_TxStart <= 1'b0;
      uart.o_TxData  <= 8'h00;
    end else begin
      t_state        <= t_next;
      wb_cnt         <= (t_state == T_WAIT_BUSY) ? wb_cnt + 2'd1 : 2'd0;
      uart.o_TxStart <= launch;
      if (launch) uart.o_TxData <= launch_dat;
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed plus randomized bench for uart_cmd_parser with a behavioural UART transmitter.
module tb_uart_cmd_parser;
  import uart_cmd_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 100;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [7:0] i_TimerColour;
  logic [7:0] o_Colour;
  logic       o_Override;
  logic       o_Error;
  logic       hold_busy  = 1'b0;
  logic       model_busy = 1'b0;
  int         busy_len   = 20;
  int         gap        = 40;

  uart_cmd_parser_if uif();
  assign uif.i_TxBusy = hold_busy | model_busy;

  uart_cmd_parser #(
    .TX_FIFO_DEPTH (DEPTH),
    .CMD_TIMEOUT   (TIMEOUT)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .uart          (uif),
    .i_TimerColour (i_TimerColour),
    .o_Colour      (o_Colour),
    .o_Override    (o_Override),
    .o_Error       (o_Error)
  );

  always #5 Clock = ~Clock;

  logic [7:0] rx_q[$];
  logic [7:0] cmd[$];
  logic [7:0] exp_tx[$];
  int         err_total      = 0;
  int         start_in_reset = 0;
  int         rx_base        = 0;
  int         err_base       = 0;
  int         tests          = 0;
  int         fails          = 0;
  logic       m_override;
  logic [7:0] m_colour;

  initial forever begin
    @(negedge Clock);
    if (o_Error === 1'b1) err_total++;
    if (Reset === 1'b1 && uif.o_TxStart !== 1'b0) start_in_reset++;
  end

  // Transmitter model: busy rises 2 cycles after start and holds for busy_len cycles.
  initial forever begin
    @(negedge Clock);
    if (uif.o_TxStart === 1'b1 && Reset === 1'b0) begin
      rx_q.push_back(uif.o_TxData);
      repeat (2) @(negedge Clock);
      model_busy = 1'b1;
      repeat (busy_len) @(negedge Clock);
      model_busy = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hex_char(input logic [3:0] n, input bit lower);
    if (n < 4'd10) return 8'h30 + 8'(n);
    return (lower ? 8'h61 : 8'h41) + 8'(n) - 8'd10;
  endfunction

  // Bytes that are invalid at the given parse depth (0 = awaiting command letter).
  function automatic logic [7:0] bad_byte(input int unsigned k, input int unsigned r);
    if (k == 0) return (r == 0) ? 8'h35 : (r == 1) ? 8'h4B : (r == 2) ? 8'h78 : 8'h40;
    if (k < 3)  return (r == 0) ? 8'h47 : (r == 1) ? 8'h7A : (r == 2) ? 8'h21 : 8'hFF;
    return (r == 0) ? 8'h47 : (r == 1) ? 8'h35 : (r == 2) ? 8'h78 : 8'h21;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge Clock);
    uif.i_Data     = b;
    uif.i_Received = 1'b1;
    @(negedge Clock);
    uif.i_Received = 1'b0;
    repeat (gap) @(negedge Clock);
  endtask

  task automatic send_all();
    foreach (cmd[i]) send_byte(cmd[i]);
  endtask

  task automatic send_cr_timed(input string tag, input logic [7:0] old_col);
    @(negedge Clock);
    uif.i_Data     = ASCII_CR;
    uif.i_Received = 1'b1;
    @(negedge Clock);
    uif.i_Received = 1'b0;
    check({tag, " override+1"}, 32'(o_Override), 32'(m_override));
    check({tag, " colour+1"}, 32'(o_Colour), 32'(old_col));
    @(negedge Clock);
    check({tag, " colour+2"}, 32'(o_Colour), 32'(m_override ? m_colour : i_TimerColour));
    repeat (gap) @(negedge Clock);
  endtask

  task automatic finish_cmd(input string tag, input int exp_err);
    int n      = exp_tx.size();
    int waited = 0;
    while ((rx_q.size() - rx_base) < n && waited < 5000) begin
      @(negedge Clock);
      waited++;
    end
    repeat (busy_len + 40) @(negedge Clock);
    check({tag, " tx count"}, rx_q.size() - rx_base, n);
    for (int i = 0; i < n && rx_base + i < rx_q.size(); i++)
      check($sformatf("%s tx byte %0d", tag, i), 32'(rx_q[rx_base + i]), 32'(exp_tx[i]));
    check({tag, " errors"}, err_total - err_base, exp_err);
    check({tag, " override"}, 32'(o_Override), 32'(m_override));
    check({tag, " colour"}, 32'(o_Colour), 32'(m_override ? m_colour : i_TimerColour));
    rx_base  = rx_q.size();
    err_base = err_total;
    cmd.delete();
    exp_tx.delete();
  endtask

  initial begin
    int unsigned kind;
    int unsigned k;
    int unsigned pos;
    logic [7:0]  v;
    int          exp_err;
    bit          lc;

    Reset          = 1'b1;
    uif.i_Received = 1'b0;
    uif.i_Data     = 8'h00;
    i_TimerColour  = 8'h00;
    m_override     = 1'b0;
    m_colour       = 8'h00;
    repeat (3) @(negedge Clock);
    check("reset TxStart", 32'(uif.o_TxStart), 32'd0);
    check("reset TxData", 32'(uif.o_TxData), 32'h00);
    check("reset Colour", 32'(o_Colour), 32'h00);
    check("reset Override", 32'(o_Override), 32'd0);
    check("reset Error", 32'(o_Error), 32'd0);
    Reset = 1'b0;
    repeat (2) @(negedge Clock);
    rx_base  = rx_q.size();
    err_base = err_total;

    // Colour command with a slow transmitter
    busy_len = 100;
    gap      = 90;
    cmd = '{ASCII_C, 8'h33, 8'h41};
    send_all();
    exp_tx = cmd;
    exp_tx.push_back(ASCII_CR);
    exp_tx.push_back(ASCII_K);
    m_override = 1'b1;
    m_colour   = 8'h3A;
    send_cr_timed("c3a", 8'h00);
    finish_cmd("c3a", 0);

    // Bad hex digit: nak, colour untouched
    busy_len = 20;
    gap      = 40;
    cmd = '{ASCII_C, 8'h34, 8'h47};
    send_all();
    exp_tx = cmd;
    exp_tx.push_back(ASCII_NAK);
    finish_cmd("c4g", 1);

    // Back to timer mode
    i_TimerColour = 8'h55;
    cmd = '{ASCII_T_LC};
    send_all();
    exp_tx = '{ASCII_T_LC, ASCII_CR, ASCII_K};
    m_override = 1'b0;
    send_cr_timed("t", 8'h3A);
    finish_cmd("t", 0);

    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      i_TimerColour = 8'($urandom);
      @(negedge Clock);
      check("timer latency", 32'(o_Colour), 32'(i_TimerColour));
    end

    // Inter-byte timeout
    cmd = '{ASCII_C, 8'h31};
    send_all();
    repeat (TIMEOUT + 20) @(negedge Clock);
    exp_tx = cmd;
    finish_cmd("timeout", 1);
    cmd = '{ASCII_C, 8'h30, 8'h30};
    send_all();
    exp_tx = cmd;
    exp_tx.push_back(ASCII_CR);
    exp_tx.push_back(ASCII_K);
    m_override = 1'b1;
    m_colour   = 8'h00;
    send_cr_timed("c00", i_TimerColour);
    finish_cmd("c00", 0);

    // Queue overflow with transmitter held busy
    hold_busy = 1'b1;
    gap       = 1;
    cmd = '{ASCII_C, 8'h39, ASCII_LF, 8'h61, ASCII_LF, ASCII_LF};
    send_all();
    repeat (3) @(negedge Clock);
    check("full held tx", rx_q.size() - rx_base, 0);
    check("full drops", err_total - err_base, 2);
    // Release busy on the same cycle as CR: push into a full queue alongside a pop.
    @(negedge Clock);
    hold_busy      = 1'b0;
    uif.i_Data     = ASCII_CR;
    uif.i_Received = 1'b1;
    @(negedge Clock);
    uif.i_Received = 1'b0;
    gap = 40;
    exp_tx = '{ASCII_C, 8'h39, ASCII_LF, 8'h61, ASCII_CR};
    m_override = 1'b1;
    m_colour   = 8'h9A;
    finish_cmd("full", 3);

    // Reset mid-command and mid-transmit
    gap = 3;
    send_byte(ASCII_C);
    send_byte(8'h37);
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    check("midrst TxStart", 32'(uif.o_TxStart), 32'd0);
    check("midrst TxData", 32'(uif.o_TxData), 32'h00);
    check("midrst Colour", 32'(o_Colour), 32'h00);
    check("midrst Override", 32'(o_Override), 32'd0);
    check("midrst Error", 32'(o_Error), 32'd0);
    repeat (3) @(negedge Clock);
    Reset      = 1'b0;
    m_override = 1'b0;
    m_colour   = 8'h00;
    for (int i = 0; i < 300 && model_busy; i++) @(negedge Clock);
    check("midrst model idle", 32'(model_busy), 32'd0);
    repeat (5) @(negedge Clock);
    rx_base  = rx_q.size();
    err_base = err_total;
    gap = 40;
    cmd = '{ASCII_T};
    send_all();
    exp_tx = '{ASCII_T, ASCII_CR, ASCII_K};
    send_cr_timed("rst T", i_TimerColour);
    finish_cmd("rst T", 0);

    // Randomized commands against the generator's own expectations
    for (int n = 0; n < 16; n++) begin
      busy_len      = int'($urandom_range(8, 30));
      i_TimerColour = 8'($urandom);
      kind          = $urandom_range(0, 3);
      v             = 8'($urandom);
      exp_err       = 0;
      if (kind <= 1) begin
        cmd.push_back($urandom_range(0, 1) ? ASCII_C : ASCII_C_LC);
        lc = 1'($urandom_range(0, 1));
        cmd.push_back(hex_char(v[7:4], lc));
        lc = 1'($urandom_range(0, 1));
        cmd.push_back(hex_char(v[3:0], lc));
        cmd.push_back(ASCII_CR);
        if (kind == 1) begin
          pos = $urandom_range(1, 3);
          cmd.insert(int'(pos), ASCII_LF);
        end
        exp_tx = cmd;
        exp_tx.push_back(ASCII_K);
        m_override = 1'b1;
        m_colour   = v;
      end else if (kind == 2) begin
        cmd.push_back($urandom_range(0, 1) ? ASCII_T : ASCII_T_LC);
        cmd.push_back(ASCII_CR);
        exp_tx = cmd;
        exp_tx.push_back(ASCII_K);
        m_override = 1'b0;
      end else begin
        k = $urandom_range(0, 3);
        if (k >= 1) cmd.push_back(ASCII_C);
        if (k >= 2) cmd.push_back(hex_char(v[7:4], 1'b0));
        if (k >= 3) cmd.push_back(hex_char(v[3:0], 1'b1));
        cmd.push_back(bad_byte(k, $urandom_range(0, 3)));
        exp_tx = cmd;
        exp_tx.push_back(ASCII_NAK);
        exp_err = 1;
      end
      send_all();
      finish_cmd($sformatf("rand%0d", n), exp_err);
    end

    check("no start in reset", start_in_reset, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Consumes bytes from the UART receiver, parses a small ASCII command protocol, and drives the WS2812 colour input. It sits between the UART receive outputs and the LED colour path. Every received byte is echoed, and an ack/nak byte is queued to the UART transmitter through a small TX FIFO. In timer mode the colour tracks the wishbone-read timer value; a command selects override mode, in which a fixed colour is held.

## Interface
Parameters:
- TX_FIFO_DEPTH, 4: TX queue depth in bytes; power of two, ≥2.
- CMD_TIMEOUT, 13300000: inter-byte timeout in Clock cycles (100 ms at 133 MHz).

Ports:
- Clock  in  1  system clock (PLL output).
- Reset  in  1  asynchronous, active-high.
- i_Received  in  1  one-cycle pulse: i_Data holds a valid received byte.
- i_Data  in  8  received byte.
- i_TxBusy  in  1  UART transmitter busy.
- i_TimerColour  in  8  colour used in timer mode.
- o_TxStart  out  1  one-cycle pulse starting a transmit of o_TxData.
- o_TxData  out  8  byte to transmit; stable from o_TxStart until i_TxBusy falls.
- o_Colour  out  8  colour to WS2812 i_Colour.
- o_Override  out  1  1 = override colour active, 0 = timer mode.
- o_Error  out  1  one-cycle pulse on parse error, timeout or TX FIFO drop.

## Operation
- Reset values: o_TxStart 0, o_TxData 8'h00, o_Colour 8'h00, o_Override 0, o_Error 0, FIFO empty, parser in P_IDLE, TX FSM in T_IDLE.
- Echo: each i_Received pushes i_Data into the FIFO in the same cycle.
- Parser states:
  - P_IDLE: 'C'/'c' goes to P_HEX_HI. 'T'/'t' sets pend_timer and goes to P_CR. CR (8'h0D) is ignored.
  - P_HEX_HI: a hex digit loads the upper nibble and goes to P_HEX_LO.
  - P_HEX_LO: a hex digit loads the lower nibble, clears pend_timer and goes to P_CR.
  - P_CR: CR commits the pending command. For a colour command, colour_reg takes the two loaded nibbles and o_Override is set to 1. For 'T', o_Override is cleared to 0. Either way 'K' (8'h4B) is queued and the parser returns to P_IDLE.
- Hex digits: 0-9, A-F, a-f.
- LF (8'h0A) is ignored in every state.
- Any other byte in any state queues '?' (8'h3F), pulses o_Error and returns to P_IDLE. No partial commit; colour_reg is unchanged.
- Response byte ('K'/'?') is pushed the cycle after its echo. Bytes arrive at most once per UART frame, so the write port never collides.
- FIFO full on push: the byte is dropped and o_Error pulses. Parser state still advances normally.
- Timeout: a counter clears on every i_Received. If the parser is not in P_IDLE and the counter reaches CMD_TIMEOUT-1, the parser returns to P_IDLE, o_Error pulses, and nothing is queued.
- o_Colour is registered: colour_reg when o_Override=1, else i_TimerColour.
- TX FSM states:
  - T_IDLE: if FIFO not empty and i_TxBusy=0, pop the head into o_TxData, pulse o_TxStart and go to T_WAIT_BUSY.
  - T_WAIT_BUSY: wait for i_TxBusy=1, then go to T_WAIT_DONE. If i_TxBusy is still 0 after 4 cycles, return to T_IDLE.
  - T_WAIT_DONE: wait for i_TxBusy=0, then go to T_IDLE.

## Timing
- Echo push: same cycle as i_Received. Earliest o_TxStart for that byte is the next cycle (FIFO empty, UART idle).
- Commit: o_Override and colour_reg update on the cycle after the CR's i_Received. o_Colour reflects the new value one further cycle later, i.e. 2 cycles after the CR strobe.
- Timer-mode colour latency: 1 cycle from i_TimerColour.
- FIFO: simultaneous push and pop when full is allowed; the pop frees the slot, so the push succeeds.
- Reset mid-command or mid-transmit: all state clears immediately. o_TxStart is never asserted during Reset.

## Structure
- Package uart_cmd_pkg holds:
  - ASCII constants: CR, LF, 'C', 'T', 'K', '?'.
  - Parser state encodings: P_IDLE, P_HEX_HI, P_HEX_LO, P_CR.
  - TX state encodings: T_IDLE, T_WAIT_BUSY, T_WAIT_DONE.
  - A hex-to-nibble function with a valid flag.
- One sub-module, tx_byte_fifo: synchronous, DEPTH/width parameters, push/pop/full/empty, first-word fall-through.

## Test plan
- Send "C3A\r" with a UART model asserting busy 2 cycles after start for 100 cycles → transmitted "C3A\rK". o_Override=1, o_Colour=8'h3A.
- After override, send "t\r" with i_TimerColour=8'h55 → transmitted "t\rK". o_Override=0, o_Colour=8'h55 within 2 cycles.
- Send "C4G" → 'G' echoed, then '?'. o_Error pulses once, o_Colour unchanged, parser in P_IDLE.
- Send "C1", then idle for CMD_TIMEOUT cycles (bench CMD_TIMEOUT=100) → o_Error pulse, no response byte. A following "C00\r" commits o_Colour=8'h00.
- Hold i_TxBusy=1 and feed 6 bytes with DEPTH=4 → first 4 queued, later pushes dropped with o_Error pulses. Release busy → exactly 4 bytes transmitted in order.
- Assert Reset mid-"C7" → all outputs return to reset values. Then "T\r" → "T\rK" transmitted.
